// File: rtl/cache_controller_if.sv
// CPU load/store and RAM handshake bundle for the cache controller.
// The controller takes the slave view; the CPU/RAM environment takes the master view.
interface cache_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        flush_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one word
// per line, flush support and saturating hit/miss counters.
module cache_controller #(
    parameter int INDEX_BITS = 5,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    cache_controller_if.slave  bus,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, COMPARE, FILL, WRITE_MEM} state_t;

    state_t             state_q, state_d;
    logic [29:0]        word_q, word_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               flush_done_q, flush_done_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0]   miss_q, miss_d;

    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic                  arr_we;
    logic [31:0]           arr_wdata;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;

    assign idx = word_q[INDEX_BITS-1:0];
    assign tag = word_q[29:INDEX_BITS];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        arr_we       = 1'b0;
        arr_wdata    = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d      = '0;
                    flush_done_d = 1'b1;
                end else if (bus.cpu_req && !ready_q) begin
                    // ready_q blocks re-accepting a request the CPU is still holding
                    word_d  = bus.cpu_addr[31:2];
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (!we_q && hit) begin
                    rdata_d = data_mem[idx];
                    ready_d = 1'b1;
                    hit_d   = sat_inc(hit_q);
                    state_d = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = we_q;
                    mem_addr_d = {word_q, 2'b00};
                    if (we_q) begin
                        mem_wdata_d = wdata_q;
                        arr_we      = hit;
                        state_d     = WRITE_MEM;
                    end else begin
                        state_d     = FILL;
                    end
                    if (we_q && hit) hit_d  = sat_inc(hit_q);
                    else             miss_d = sat_inc(miss_q);
                end
            end
            FILL: begin
                if (bus.mem_ack && mem_req_q) begin
                    arr_we       = 1'b1;
                    arr_wdata    = bus.mem_rdata;
                    valid_d[idx] = 1'b1;
                    rdata_d      = bus.mem_rdata;
                    ready_d      = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            WRITE_MEM: begin
                if (bus.mem_ack && mem_req_q) begin
                    ready_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            valid_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag is rewritten on store hits too; it is unchanged there, so one enable suffices.
    always_ff @(posedge clock) begin
        if (arr_we) begin
            data_mem[idx] <= arr_wdata;
            tag_mem[idx]  <= tag;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;
endmodule
